mandel_cmd_parser: RTL and testbench

- Upstream command stage for the Mandelbrot engine.
- Consumes the byte stream from the UART receiver (RX8, running in the clk24M domain) and assembles the 13-byte render command.
- Presents the decoded parameter set atomically to the iteration engine and issues a single start pulse once the engine is idle.
- Adds clock-domain synchronisation, inter-byte timeout resync and command validation.

---
 rtl/mandel_cmd_parser_if.sv | 27 ++
 rtl/mandel_cmd_parser.sv | 155 +++++++++++++++
 tb/tb_mandel_cmd_parser.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mandel_cmd_parser_if.sv
// Byte-in / parameter-out bundle between the UART receiver, the command
// parser and the Mandelbrot iteration engine.
interface mandel_cmd_parser_if;
    logic [7:0]  r_data;
    logic        r_ready;
    logic        busy;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [15:0] cxs;
    logic [15:0] cys;
    logic [15:0] dcx;
    logic [15:0] dcy;
    logic [15:0] max_iterate;
    logic        start;
    logic        frame_err;
    logic [3:0]  byte_cnt;

    modport master (
        output r_data, r_ready, busy,
        input  pix_x, pix_y, cxs, cys, dcx, dcy, max_iterate, start, frame_err, byte_cnt
    );

    modport slave (
        input  r_data, r_ready, busy,
        output pix_x, pix_y, cxs, cys, dcx, dcy, max_iterate, start, frame_err, byte_cnt
    );
endinterface

// File: rtl/mandel_cmd_parser.sv
// Command parser for the Mandelbrot engine: synchronises the RX8 byte strobe,
// assembles a 13-byte big-endian render command into shadow registers,
// validates it, publishes it atomically and hands one start pulse to the
// engine once it is idle. A stalled partial frame is dropped after a timeout.
module mandel_cmd_parser #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 700000,
    parameter int N_BYTES        = 13
) (
    input  logic              clk,
    input  logic              rst,
    mandel_cmd_parser_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ready_s;
    logic                   ready_d;
    logic                   accept;
    logic                   last_byte;
    logic                   timeout;
    logic [TW-1:0]          to_cnt;
    logic [3:0]             byte_cnt;
    logic                   frame_done;
    logic                   pending;

    logic [8:0]  sh_pix_x;
    logic [7:0]  sh_pix_y;
    logic [15:0] sh_cxs, sh_cys, sh_dcx, sh_dcy, sh_mi;

    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [15:0] cxs, cys, dcx, dcy, max_iterate;
    logic        start;
    logic        frame_err;

    assign ready_s   = sync_q[SYNC_STAGES-1];
    assign accept    = ready_s & ~ready_d;
    assign last_byte = (byte_cnt == 4'(N_BYTES - 1));
    // An acceptance in the timeout cycle takes precedence over the resync.
    assign timeout   = !accept && (byte_cnt != 4'd0) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign bus.pix_x       = pix_x;
    assign bus.pix_y       = pix_y;
    assign bus.cxs         = cxs;
    assign bus.cys         = cys;
    assign bus.dcx         = dcx;
    assign bus.dcy         = dcy;
    assign bus.max_iterate = max_iterate;
    assign bus.start       = start;
    assign bus.frame_err   = frame_err;
    assign bus.byte_cnt    = byte_cnt;

    // Bring the RX8 ready level into clk and keep a delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            ready_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.r_ready};
            ready_d <= ready_s;
        end
    end

    // Capture bytes into the shadow set, track frame position and run the inter-byte timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= 4'd0;
            to_cnt     <= '0;
            frame_done <= 1'b0;
            sh_pix_x   <= '0;
            sh_pix_y   <= '0;
            sh_cxs     <= '0;
            sh_cys     <= '0;
            sh_dcx     <= '0;
            sh_dcy     <= '0;
            sh_mi      <= '0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                case (byte_cnt)
                    4'd0:    sh_pix_x[8]    <= bus.r_data[0];
                    4'd1:    sh_pix_x[7:0]  <= bus.r_data;
                    4'd2:    sh_pix_y       <= bus.r_data;
                    4'd3:    sh_cxs[15:8]   <= bus.r_data;
                    4'd4:    sh_cxs[7:0]    <= bus.r_data;
                    4'd5:    sh_cys[15:8]   <= bus.r_data;
                    4'd6:    sh_cys[7:0]    <= bus.r_data;
                    4'd7:    sh_dcx[15:8]   <= bus.r_data;
                    4'd8:    sh_dcx[7:0]    <= bus.r_data;
                    4'd9:    sh_dcy[15:8]   <= bus.r_data;
                    4'd10:   sh_dcy[7:0]    <= bus.r_data;
                    4'd11:   sh_mi[15:8]    <= bus.r_data;
                    4'd12:   sh_mi[7:0]     <= bus.r_data;
                    default: ;
                endcase
                to_cnt <= '0;
                if (last_byte) begin
                    byte_cnt   <= 4'd0;
                    frame_done <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 4'd1;
                end
            end else if (byte_cnt == 4'd0) begin
                to_cnt <= '0;
            end else if (timeout) begin
                // Every shadow bit is rewritten by a full frame, so dropping the position is enough.
                byte_cnt <= 4'd0;
                to_cnt   <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // Validate completed frames, publish them atomically and issue the start handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_x       <= 9'd510;
            pix_y       <= 8'd255;
            cxs         <= '0;
            cys         <= '0;
            dcx         <= '0;
            dcy         <= '0;
            max_iterate <= 16'd100;
            start       <= 1'b0;
            frame_err   <= 1'b0;
            pending     <= 1'b0;
        end else begin
            start     <= 1'b0;
            frame_err <= timeout;
            if (frame_done) begin
                if (sh_mi == 16'd0) begin
                    frame_err <= 1'b1;
                end else begin
                    pix_x       <= sh_pix_x;
                    pix_y       <= sh_pix_y;
                    cxs         <= sh_cxs;
                    cys         <= sh_cys;
                    dcx         <= sh_dcx;
                    dcy         <= sh_dcy;
                    max_iterate <= sh_mi;
                end
            end
            // A frame landing while start fires is covered by that same pulse,
            // since the outputs update on the same edge.
            if (pending && !bus.busy) begin
                start   <= 1'b1;
                pending <= 1'b0;
            end else if (frame_done && (sh_mi != 16'd0)) begin
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mandel_cmd_parser.sv
// Self-checking bench for mandel_cmd_parser: frames are driven byte by byte
// through the asynchronous ready strobe; every frame expected to be started
// is pushed on a scoreboard and popped when start is seen.
module tb_mandel_cmd_parser;
    localparam int TO = 300;

    typedef struct packed {
        logic [8:0]  px;
        logic [7:0]  py;
        logic [15:0] cxs;
        logic [15:0] cys;
        logic [15:0] dcx;
        logic [15:0] dcy;
        logic [15:0] mi;
    } params_t;

    localparam params_t RST_P = '{px: 9'd510, py: 8'd255, cxs: 16'h0, cys: 16'h0,
                                  dcx: 16'h0, dcy: 16'h0, mi: 16'd100};

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    int      checks = 0;
    int      failures = 0;
    int      starts = 0;
    int      errs = 0;
    int      cyc = 0;
    int      start_cyc = 0;
    int      last_raise = 0;
    params_t exp_q[$];
    params_t mon_exp;
    params_t cur;

    mandel_cmd_parser_if ifc();

    mandel_cmd_parser #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .N_BYTES(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic params_t dut_out();
        return {ifc.pix_x, ifc.pix_y, ifc.cxs, ifc.cys, ifc.dcx, ifc.dcy, ifc.max_iterate};
    endfunction

    // Scoreboard side: every start pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && ifc.start === 1'b1) begin
            starts++;
            start_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_start actual=1 required=0");
            end else begin
                mon_exp = exp_q.pop_front();
                if (dut_out() !== mon_exp) begin
                    failures++;
                    $display("FAIL start_params actual=%h required=%h", dut_out(), mon_exp);
                end
            end
        end
        if (!rst && ifc.frame_err === 1'b1) errs++;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ifc.r_data  = b;
        ifc.r_ready = 1'b1;
        last_raise  = cyc;
        repeat (4) @(negedge clk);
        ifc.r_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input params_t p, input logic [6:0] junk, input int nbytes);
        logic [7:0] b [13];
        b[0]  = {junk, p.px[8]};
        b[1]  = p.px[7:0];
        b[2]  = p.py;
        b[3]  = p.cxs[15:8]; b[4]  = p.cxs[7:0];
        b[5]  = p.cys[15:8]; b[6]  = p.cys[7:0];
        b[7]  = p.dcx[15:8]; b[8]  = p.dcx[7:0];
        b[9]  = p.dcy[15:8]; b[10] = p.dcy[7:0];
        b[11] = p.mi[15:8];  b[12] = p.mi[7:0];
        for (int i = 0; i < nbytes; i++) send_byte(b[i]);
    endtask

    task automatic wait_err(input int e0);
        for (int i = 0; i < TO + 100 && errs == e0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (dut_out() !== RST_P) begin
            failures++; $display("FAIL reset_outputs actual=%h required=%h", dut_out(), RST_P);
        end
        checks++;
        if (ifc.start !== 1'b0) begin
            failures++; $display("FAIL reset_start actual=%b required=0", ifc.start);
        end
        checks++;
        if (ifc.byte_cnt !== 4'd0) begin
            failures++; $display("FAIL reset_byte_cnt actual=%0d required=0", ifc.byte_cnt);
        end
        checks++;
        if (ifc.frame_err !== 1'b0) begin
            failures++; $display("FAIL reset_frame_err actual=%b required=0", ifc.frame_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cur = RST_P;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_valid_idle();
        params_t p;
        int s0;
        p = '{px: 9'd510, py: 8'd255, cxs: 16'hE000, cys: 16'hF000,
              dcx: 16'h0020, dcy: 16'h0020, mi: 16'h0064};
        s0 = starts;
        exp_q.push_back(p);
        send_frame(p, 7'h00, 13);
        repeat (10) @(negedge clk);
        checks++;
        if (starts != s0 + 1) begin
            failures++; $display("FAIL idle_start_count actual=%0d required=%0d", starts - s0, 1);
        end
        checks++;
        if (start_cyc - last_raise < 4 || start_cyc - last_raise > 5) begin
            failures++; $display("FAIL idle_start_latency actual=%0d required=4..5", start_cyc - last_raise);
        end
        checks++;
        if (ifc.byte_cnt !== 4'd0) begin
            failures++; $display("FAIL idle_byte_cnt actual=%0d required=0", ifc.byte_cnt);
        end
        cur = p;
    endtask

    task automatic test_busy_overwrite();
        params_t a, b;
        int s0;
        a = '{px: 9'd100, py: 8'd50, cxs: 16'h1234, cys: 16'h5678,
              dcx: 16'h0011, dcy: 16'h0022, mi: 16'h0032};
        b = '{px: 9'd300, py: 8'd200, cxs: 16'hABCD, cys: 16'h4321,
              dcx: 16'h0101, dcy: 16'h0202, mi: 16'h00C8};
        s0 = starts;
        @(negedge clk);
        ifc.busy = 1'b1;
        send_frame(a, 7'h55, 13);
        repeat (5) @(negedge clk);
        checks++;
        if (dut_out() !== a) begin
            failures++; $display("FAIL busy_frame_a actual=%h required=%h", dut_out(), a);
        end
        exp_q.push_back(b);
        send_frame(b, 7'h2A, 13);
        repeat (20) @(negedge clk);
        checks++;
        if (starts != s0) begin
            failures++; $display("FAIL busy_no_start actual=%0d required=0", starts - s0);
        end
        ifc.busy = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.start !== 1'b1) begin
            failures++; $display("FAIL busy_release_start actual=%b required=1", ifc.start);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (starts != s0 + 1 || exp_q.size() != 0) begin
            failures++; $display("FAIL busy_single_start actual=%0d required=1", starts - s0);
        end
        checks++;
        if (ifc.max_iterate !== 16'd200) begin
            failures++; $display("FAIL busy_max_iterate actual=%0d required=200", ifc.max_iterate);
        end
        cur = b;
    endtask

    task automatic test_timeout();
        params_t p, c;
        int e0, s0;
        p = '{px: 9'd7, py: 8'd9, cxs: 16'h1111, cys: 16'h2222,
              dcx: 16'h3333, dcy: 16'h4444, mi: 16'h0555};
        c = '{px: 9'd257, py: 8'd128, cxs: 16'h8001, cys: 16'h7FFE,
              dcx: 16'h0003, dcy: 16'h0004, mi: 16'h1000};
        e0 = errs;
        s0 = starts;
        send_frame(p, 7'h7F, 5);
        checks++;
        if (ifc.byte_cnt !== 4'd5) begin
            failures++; $display("FAIL timeout_partial_cnt actual=%0d required=5", ifc.byte_cnt);
        end
        wait_err(e0);
        repeat (2) @(negedge clk);
        checks++;
        if (errs != e0 + 1) begin
            failures++; $display("FAIL timeout_err actual=%0d required=1", errs - e0);
        end
        checks++;
        if (ifc.byte_cnt !== 4'd0) begin
            failures++; $display("FAIL timeout_byte_cnt actual=%0d required=0", ifc.byte_cnt);
        end
        checks++;
        if (dut_out() !== cur) begin
            failures++; $display("FAIL timeout_outputs actual=%h required=%h", dut_out(), cur);
        end
        exp_q.push_back(c);
        send_frame(c, 7'h01, 13);
        repeat (10) @(negedge clk);
        checks++;
        if (starts != s0 + 1 || exp_q.size() != 0) begin
            failures++; $display("FAIL timeout_next_frame actual=%0d required=1", starts - s0);
        end
        cur = c;
    endtask

    task automatic test_reject_long_ready();
        params_t r;
        int e0, s0;
        r = '{px: 9'd1, py: 8'd2, cxs: 16'h0A0A, cys: 16'h0B0B,
              dcx: 16'h0C0C, dcy: 16'h0D0D, mi: 16'h0000};
        e0 = errs;
        s0 = starts;
        send_frame(r, 7'h10, 13);
        repeat (10) @(negedge clk);
        checks++;
        if (errs != e0 + 1 || starts != s0) begin
            failures++; $display("FAIL reject actual=err%0d/start%0d required=err1/start0", errs - e0, starts - s0);
        end
        checks++;
        if (dut_out() !== cur) begin
            failures++; $display("FAIL reject_outputs actual=%h required=%h", dut_out(), cur);
        end
        @(negedge clk);
        ifc.r_data  = 8'hAB;
        ifc.r_ready = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (ifc.byte_cnt !== 4'd1) begin
            failures++; $display("FAIL long_ready actual=%0d required=1", ifc.byte_cnt);
        end
        ifc.r_ready = 1'b0;
        e0 = errs;
        wait_err(e0);
        repeat (2) @(negedge clk);
        checks++;
        if (errs != e0 + 1 || ifc.byte_cnt !== 4'd0) begin
            failures++; $display("FAIL long_ready_resync actual=%0d required=0", ifc.byte_cnt);
        end
    endtask

    task automatic test_back_to_back();
        params_t p1, p2;
        int s0;
        p1 = '{px: 9'd64, py: 8'd48, cxs: 16'hC000, cys: 16'hE800,
               dcx: 16'h0040, dcy: 16'h0041, mi: 16'h00FF};
        p2 = '{px: 9'd480, py: 8'd240, cxs: 16'hD800, cys: 16'hEC00,
               dcx: 16'h0010, dcy: 16'h0012, mi: 16'hFFFF};
        s0 = starts;
        exp_q.push_back(p1);
        send_frame(p1, 7'h3C, 13);
        exp_q.push_back(p2);
        send_frame(p2, 7'h43, 13);
        repeat (10) @(negedge clk);
        checks++;
        if (starts != s0 + 2 || exp_q.size() != 0) begin
            failures++; $display("FAIL back_to_back actual=%0d required=2", starts - s0);
        end
        cur = p2;
    endtask

    task automatic test_reset_mid_frame();
        params_t p, q;
        int s0;
        p = '{px: 9'd11, py: 8'd22, cxs: 16'h0033, cys: 16'h0044,
              dcx: 16'h0055, dcy: 16'h0066, mi: 16'h0077};
        q = '{px: 9'd399, py: 8'd199, cxs: 16'hF123, cys: 16'h0E45,
              dcx: 16'h0007, dcy: 16'h0009, mi: 16'h0321};
        @(negedge clk);
        ifc.busy = 1'b1;
        send_frame(p, 7'h00, 13);
        send_frame(q, 7'h66, 7);
        checks++;
        if (ifc.byte_cnt !== 4'd7) begin
            failures++; $display("FAIL midframe_cnt actual=%0d required=7", ifc.byte_cnt);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (dut_out() !== RST_P || ifc.byte_cnt !== 4'd0) begin
            failures++; $display("FAIL midframe_reset actual=%h required=%h", dut_out(), RST_P);
        end
        @(negedge clk);
        rst = 1'b0;
        ifc.busy = 1'b0;
        s0 = starts;
        repeat (20) @(negedge clk);
        checks++;
        if (starts != s0) begin
            failures++; $display("FAIL midframe_stale_start actual=%0d required=0", starts - s0);
        end
        exp_q.push_back(q);
        send_frame(q, 7'h19, 13);
        repeat (10) @(negedge clk);
        checks++;
        if (starts != s0 + 1 || exp_q.size() != 0) begin
            failures++; $display("FAIL midframe_new_frame actual=%0d required=1", starts - s0);
        end
        cur = q;
    endtask

    initial begin
        ifc.r_data  = 8'h00;
        ifc.r_ready = 1'b0;
        ifc.busy    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_valid_idle();
        test_busy_overwrite();
        test_timeout();
        test_reject_long_ready();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
